// File: rtl/lcd_bounce_block.sv
// lcd_bounce_block: RGB565 pixel source drawing a solid square that bounces
// around the active area. Position advances once every MOVE_DIV frames,
// triggered by the lcd_vs rising edge; colour advances on every bounce.
// Optional: define LCD_BOUNCE_BORDER_EN to draw a 1-pixel white border.
module lcd_bounce_block #(
  parameter int unsigned H_DISP   = 480,
  parameter int unsigned V_DISP   = 272,
  parameter int unsigned BLK_SIZE = 32,
  parameter int unsigned STEP     = 2,
  parameter int unsigned MOVE_DIV = 1,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic        lcd_vs,
  input  logic [9:0]  pixel_xpos,
  input  logic [9:0]  pixel_ypos,
  output logic [15:0] pixel_data
);

  localparam logic [10:0] X_MAX    = 11'(H_DISP - BLK_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(V_DISP - BLK_SIZE);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] BLK_W    = 11'(BLK_SIZE);
  localparam logic [7:0]  DIV_LAST = 8'(MOVE_DIV - 1);

  typedef enum logic [1:0] {S_WAIT, S_MOVE_X, S_MOVE_Y, S_COLOR} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_blk_x, r_blk_y, w_blk_x_nxt, w_blk_y_nxt;
  logic        r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
  logic        r_bounce_x, r_bounce_y, w_bounce_x_nxt, w_bounce_y_nxt;
  logic [2:0]  r_col_idx, w_col_idx_nxt;
  logic [7:0]  r_frame_cnt;
  logic        r_vs_d;
  logic        w_vs_rise, w_move_req;
  logic        w_in_sq, w_border;
  logic [10:0] w_px, w_py, w_bx, w_by;
  logic [15:0] w_sq_color, w_pix_nxt;

  // One axis step: move toward the current direction, clamp and reverse at the edge.
  function automatic void axis_step(input logic [9:0] pos, input logic dir,
                                    input logic [10:0] lim, output logic [9:0] pos_n,
                                    output logic dir_n, output logic bounce);
    logic [10:0] p;
    p      = {1'b0, pos};
    pos_n  = pos;
    dir_n  = dir;
    bounce = 1'b0;
    if (dir) begin
      if (p + STEP_W >= lim) begin
        pos_n  = 10'(lim);
        dir_n  = 1'b0;
        bounce = 1'b1;
      end else begin
        pos_n = 10'(p + STEP_W);
      end
    end else begin
      if (p <= STEP_W) begin
        pos_n  = 10'd0;
        dir_n  = 1'b1;
        bounce = 1'b1;
      end else begin
        pos_n = 10'(p - STEP_W);
      end
    end
  endfunction

  assign w_vs_rise  = lcd_vs & ~r_vs_d;
  assign w_move_req = w_vs_rise && (r_frame_cnt == DIV_LAST);

  // Frame edge detect and frame divider; counts every rise regardless of FSM state.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vs_d      <= 1'b1;
      r_frame_cnt <= 8'd0;
    end else begin
      r_vs_d <= lcd_vs;
      if (w_vs_rise) begin
        r_frame_cnt <= (r_frame_cnt == DIV_LAST) ? 8'd0 : r_frame_cnt + 8'd1;
      end
    end
  end

  // FSM state and motion registers.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_WAIT;
      r_blk_x    <= 10'd0;
      r_blk_y    <= 10'd0;
      r_dir_x    <= 1'b1;
      r_dir_y    <= 1'b1;
      r_bounce_x <= 1'b0;
      r_bounce_y <= 1'b0;
      r_col_idx  <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_blk_x    <= w_blk_x_nxt;
      r_blk_y    <= w_blk_y_nxt;
      r_dir_x    <= w_dir_x_nxt;
      r_dir_y    <= w_dir_y_nxt;
      r_bounce_x <= w_bounce_x_nxt;
      r_bounce_y <= w_bounce_y_nxt;
      r_col_idx  <= w_col_idx_nxt;
    end
  end

  // Next-state: X step, Y step, then one colour advance if either axis bounced.
  always_comb begin
    w_state_nxt    = r_state;
    w_blk_x_nxt    = r_blk_x;
    w_blk_y_nxt    = r_blk_y;
    w_dir_x_nxt    = r_dir_x;
    w_dir_y_nxt    = r_dir_y;
    w_bounce_x_nxt = r_bounce_x;
    w_bounce_y_nxt = r_bounce_y;
    w_col_idx_nxt  = r_col_idx;
    case (r_state)
      S_WAIT: begin
        if (w_move_req) w_state_nxt = S_MOVE_X;
      end
      S_MOVE_X: begin
        axis_step(r_blk_x, r_dir_x, X_MAX, w_blk_x_nxt, w_dir_x_nxt, w_bounce_x_nxt);
        w_state_nxt = S_MOVE_Y;
      end
      S_MOVE_Y: begin
        axis_step(r_blk_y, r_dir_y, Y_MAX, w_blk_y_nxt, w_dir_y_nxt, w_bounce_y_nxt);
        w_state_nxt = S_COLOR;
      end
      S_COLOR: begin
        if (r_bounce_x | r_bounce_y) w_col_idx_nxt = r_col_idx + 3'd1;
        w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Palette lookup for the current square colour.
  always_comb begin
    w_sq_color = 16'hF800;
    case (r_col_idx)
      3'd0:    w_sq_color = 16'hF800;
      3'd1:    w_sq_color = 16'h07E0;
      3'd2:    w_sq_color = 16'h001F;
      3'd3:    w_sq_color = 16'hFFE0;
      3'd4:    w_sq_color = 16'h07FF;
      3'd5:    w_sq_color = 16'hF81F;
      3'd6:    w_sq_color = 16'hFFFF;
      default: w_sq_color = 16'hFD20;
    endcase
  end

  assign w_px = {1'b0, pixel_xpos};
  assign w_py = {1'b0, pixel_ypos};
  assign w_bx = {1'b0, r_blk_x};
  assign w_by = {1'b0, r_blk_y};
  assign w_in_sq = (w_px >= w_bx) && (w_px < w_bx + BLK_W) &&
                   (w_py >= w_by) && (w_py < w_by + BLK_W);

`ifdef LCD_BOUNCE_BORDER_EN
  assign w_border = (pixel_xpos == 10'd0) || (pixel_xpos == 10'(H_DISP - 1)) ||
                    (pixel_ypos == 10'd0) || (pixel_ypos == 10'(V_DISP - 1));
`else
  assign w_border = 1'b0;
`endif

  // Pixel colour select: border over square over background.
  always_comb begin
    w_pix_nxt = BG_COLOR;
    if (w_border)     w_pix_nxt = 16'hFFFF;
    else if (w_in_sq) w_pix_nxt = w_sq_color;
  end

  // Registered pixel output, one clock after the coordinate request.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pixel_data <= 16'h0000;
    else            pixel_data <= w_pix_nxt;
  end

endmodule

// File: tb/tb_lcd_bounce_block.sv
// Scoreboard bench for lcd_bounce_block: two instances (default geometry and a
// small 40x64 / STEP=3 / MOVE_DIV=4 one) driven with random pixel requests
// each frame, compared against a frame-level reference model.
module tb_lcd_bounce_block;

  localparam int P_H[2]   = '{480, 40};
  localparam int P_V[2]   = '{272, 64};
  localparam int P_B[2]   = '{32, 32};
  localparam int P_S[2]   = '{2, 3};
  localparam int P_DIV[2] = '{1, 4};
  localparam logic [15:0] PAL[8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                                      16'h07FF, 16'hF81F, 16'hFFFF, 16'hFD20};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic [9:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [15:0] pd0, pd1;
  logic        req_v = 1'b0;

  typedef struct packed { logic [15:0] e0; logic [15:0] e1; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // reference model state, one entry per instance
  int m_bx[2], m_by[2], m_dx[2], m_dy[2], m_col[2], m_cnt[2];

  always #5 clk = ~clk;

  lcd_bounce_block u_dut0 (
    .lcd_clk(clk), .sys_rst_n(rst_n), .lcd_vs(vs),
    .pixel_xpos(x0), .pixel_ypos(y0), .pixel_data(pd0));

  lcd_bounce_block #(.H_DISP(40), .V_DISP(64), .BLK_SIZE(32), .STEP(3), .MOVE_DIV(4))
  u_dut1 (
    .lcd_clk(clk), .sys_rst_n(rst_n), .lcd_vs(vs),
    .pixel_xpos(x1), .pixel_ypos(y1), .pixel_data(pd1));

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bx[i] = 0; m_by[i] = 0; m_dx[i] = 1; m_dy[i] = 1; m_col[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // Move one coordinate by STEP inside [0, lim], reversing on contact.
  task automatic step_axis(input int s, input int lim, inout int p, inout int d, output bit hit);
    hit = 0;
    if (d == 1) begin
      if (p + s >= lim) begin p = lim; d = 0; hit = 1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1; hit = 1; end
      else p = p - s;
    end
  endtask

  // One frame boundary; idle==0 means the previous move is still in flight.
  task automatic model_frame(input int i, input bit idle);
    bit hx, hy, req;
    req = (m_cnt[i] == P_DIV[i] - 1);
    m_cnt[i] = req ? 0 : m_cnt[i] + 1;
    if (req && idle) begin
      step_axis(P_S[i], P_H[i] - P_B[i], m_bx[i], m_dx[i], hx);
      step_axis(P_S[i], P_V[i] - P_B[i], m_by[i], m_dy[i], hy);
      if (hx || hy) m_col[i] = (m_col[i] + 1) % 8;
    end
  endtask

  function automatic logic [15:0] exp_px(input int i, input int x, input int y);
`ifdef LCD_BOUNCE_BORDER_EN
    if (x == 0 || x == P_H[i] - 1 || y == 0 || y == P_V[i] - 1) return 16'hFFFF;
`endif
    if (x >= m_bx[i] && x < m_bx[i] + P_B[i] && y >= m_by[i] && y < m_by[i] + P_B[i])
      return PAL[m_col[i]];
    return 16'h0000;
  endfunction

  // Issue one request to both instances and queue the expected responses.
  task automatic req(input int xa, input int ya, input int xb, input int yb);
    exp_t e;
    @(negedge clk);
    x0 = 10'(xa); y0 = 10'(ya); x1 = 10'(xb); y1 = 10'(yb);
    e.e0 = exp_px(0, xa, ya);
    e.e1 = exp_px(1, xb, yb);
    exp_q.push_back(e);
    req_v = 1'b1;
  endtask

  task automatic end_reqs();
    @(negedge clk);
    req_v = 1'b0;
  endtask

  // Pick a coordinate: random, inside the square, just past its edges, or on the frame edge.
  task automatic pick(input int i, output int x, output int y);
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: begin x = $urandom_range(0, P_H[i] - 1); y = $urandom_range(0, P_V[i] - 1); end
      1: begin
        x = m_bx[i] + $urandom_range(0, P_B[i] - 1);
        y = m_by[i] + $urandom_range(0, P_B[i] - 1);
      end
      2: begin
        x = ($urandom_range(0, 1) == 1) ? m_bx[i] + P_B[i] : m_bx[i] - 1;
        y = ($urandom_range(0, 1) == 1) ? m_by[i] + P_B[i] - 1 : m_by[i];
        if (x < 0 || x >= P_H[i]) x = m_bx[i];
      end
      default: begin
        x = ($urandom_range(0, 1) == 1) ? 0 : P_H[i] - 1;
        y = $urandom_range(0, P_V[i] - 1);
      end
    endcase
  endtask

  task automatic rand_reqs(input int n);
    int xa, ya, xb, yb;
    for (int k = 0; k < n; k++) begin
      pick(0, xa, ya);
      pick(1, xb, yb);
      req(xa, ya, xb, yb);
    end
    end_reqs();
  endtask

  // Frame boundary; optionally a second rise while the FSM is still busy.
  task automatic frame(input bit double_rise);
    @(negedge clk);
    vs = 1'b1;
    model_frame(0, 1); model_frame(1, 1);
    if (double_rise) begin
      @(negedge clk); vs = 1'b0;
      @(negedge clk); vs = 1'b1;
      model_frame(0, 0); model_frame(1, 0);
    end
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (8) @(negedge clk);
    rand_reqs(8);
  endtask

  // Monitor: every accepted request produces pixel_data one clock later.
  always @(posedge clk) begin
    if (req_v) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow: got response with empty queue, expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pix_dut0", pd0, e.e0);
        check("pix_dut1", pd1, e.e1);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_dut0", pd0, 16'h0000);
    check("reset_dut1", pd1, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    // lcd_vs held high out of reset: no movement expected
    repeat (5) @(negedge clk);
    req(0, 0, 0, 0);
    req(40, 40, 35, 35);
    req(31, 31, 31, 31);
    req(32, 5, 32, 5);
    end_reqs();
    @(negedge clk);
    vs = 1'b0;
    repeat (4) @(negedge clk);

    for (int f = 0; f < 260; f++) begin
      if (f == 130) begin
        // reset in the middle of a move
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_dut0", pd0, 16'h0000);
        check("midreset_dut1", pd1, 16'h0000);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rand_reqs(4);
      end
      frame((f % 50) == 25);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bounce_block.md
Name: lcd_bounce_block

Overview:
- Pixel source for `lcd_driver`, drop-in alternative to the colour-bar pattern generator.
- Returns RGB565 `pixel_data` for the (`pixel_xpos`, `pixel_ypos`) requested by the driver.
- Draws a solid square that bounces around the active area on a fixed background.
- Square position updates once per frame, triggered by the `lcd_vs` frame boundary; square colour advances on every bounce.

Parameters:
- H_DISP, 480, active width in pixels.
- V_DISP, 272, active height in pixels.
- BLK_SIZE, 32, square edge length in pixels (1..min(H_DISP,V_DISP)).
- STEP, 2, pixels moved per axis per update (1..BLK_SIZE).
- MOVE_DIV, 1, frames per position update (1..255).
- BG_COLOR, 16'h0000, background RGB565.

Ports:
- lcd_clk  input  1  pixel clock.
- sys_rst_n  input  1  asynchronous active-low reset (already gated with PLL lock upstream).
- lcd_vs  input  1  vertical sync from `lcd_driver`; a rising edge marks frame end.
- pixel_xpos  input  10  requested column, 0..H_DISP-1.
- pixel_ypos  input  10  requested row, 0..V_DISP-1.
- pixel_data  output  16  RGB565 for the requested pixel.

Behaviour:
- Clocking/reset:
  - Single clock `lcd_clk`; all flops reset asynchronously on sys_rst_n=0.
  - Reset values: pixel_data=16'h0000, blk_x=0, blk_y=0, dir_x=1 (right), dir_y=1 (down), col_idx=0, frame_cnt=0, state=S_WAIT.
  - vs_d (delayed lcd_vs) resets to 1, so no spurious edge is seen when lcd_vs is high out of reset.
- Pixel path:
  - pixel_data registered, latency exactly 1 lcd_clk from pixel_xpos/pixel_ypos.
  - Inside square (blk_x <= xpos < blk_x+BLK_SIZE and blk_y <= ypos < blk_y+BLK_SIZE): output palette[col_idx].
  - Otherwise: output BG_COLOR.
- Palette (RGB565, 3-bit index, wraps 7->0): F800, 07E0, 001F, FFE0, 07FF, F81F, FFFF, FD20.
- Frame edge:
  - vs_rise = lcd_vs & ~vs_d.
  - On vs_rise: frame_cnt increments. When frame_cnt reaches MOVE_DIV-1, it clears and a move is requested.
- FSM:
  - S_WAIT -> S_MOVE_X on a move request; otherwise stay.
  - S_MOVE_X: update blk_x/dir_x, capture bounce_x -> S_MOVE_Y.
  - S_MOVE_Y: update blk_y/dir_y, capture bounce_y -> S_COLOR.
  - S_COLOR: col_idx += 1 if bounce_x|bounce_y (once only, even at a corner) -> S_WAIT.
  - Total 3 cycles, completing during vertical blanking. Position registers are never modified while in S_WAIT.
- Axis update (X shown; Y identical with V_DISP):
  - dir_x=1 and blk_x+STEP >= H_DISP-BLK_SIZE: blk_x=H_DISP-BLK_SIZE, dir_x=0, bounce_x=1.
  - dir_x=1 otherwise: blk_x += STEP.
  - dir_x=0 and blk_x <= STEP: blk_x=0, dir_x=1, bounce_x=1.
  - dir_x=0 otherwise: blk_x -= STEP.
  - Arithmetic in 11 bits, so no wrap; the square never leaves the active area.
- Edge cases:
  - A vs_rise arriving while not in S_WAIT still increments frame_cnt, but does not restart the FSM.
  - Reset mid-move returns everything to reset values immediately.

Optional Feature:
- Macro: LCD_BOUNCE_BORDER_EN.
- Defined: pixels with xpos==0, xpos==H_DISP-1, ypos==0 or ypos==V_DISP-1 output 16'hFFFF, with priority over both square and background. Latency unchanged.
- Undefined: no border; edge pixels follow the normal square/background rule.

Test Plan:
- Reset release with lcd_vs=1, then lcd_vs held high → pixel_data=0000 one cycle after reset and no movement; a request at (0,0) returns F800 and (40,40) returns BG_COLOR.
- Defaults, 10 vs_rise edges → blk_x=20, blk_y=20; (20,20) returns F800 and (52,20) returns 0000, each one clock after the request.
- Preload-equivalent: run 212 frames (y hits 272-32=240 exactly at frame 120) → at frame 120 dir_y=0, blk_y=240, col_idx=1; the next frame gives blk_y=238.
- STEP=3, H_DISP=40, BLK_SIZE=32 → x sequence 0,3,6,8(bounce),5,2,0(bounce); col_idx increments at exactly those two frames.
- Square H_DISP=V_DISP=64, BLK_SIZE=32, STEP=2 → x and y bounce on the same frame; col_idx advances by exactly 1.
- MOVE_DIV=4 → position changes only on every 4th vs_rise. With LCD_BOUNCE_BORDER_EN defined, (0,100) and (479,0) return FFFF; without it they return BG_COLOR or the square colour.
